// File: rtl/mips_issue_ctrl_pkg.sv
// Shared opcodes, instruction field layout and FSM encoding for the MIPS issue controller.
package mips_issue_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ST_W    = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

  localparam logic [ST_W-1:0] ST_RUN   = 2'd0;
  localparam logic [ST_W-1:0] ST_STALL = 2'd1;
  localparam logic [ST_W-1:0] ST_FLUSH = 2'd2;

  // OP[31:26], RS[25:21], RT[20:16], remaining bits unused by hazard decode
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [15:0]      rest;
  } instr_t;

  // rt is a true source only for R-type, SW and BEQ
  function automatic logic reads_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/mips_issue_ctrl_if.sv
// Fetch-side handshake, pipeline controls and issue-side outputs of the issue controller.
interface mips_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  import mips_issue_ctrl_pkg::*;

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               hold;
  logic               br_taken;
  logic [INSTR_W-1:0] issue_instr;
  logic               issue_valid;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output in_valid, in_instr, hold, br_taken,
    input  in_ready, issue_instr, issue_valid, bubble_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_instr, hold, br_taken,
    output in_ready, issue_instr, issue_valid, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/mips_issue_ctrl_fifo.sv
// Instruction buffer: DEPTH x 32 FIFO with synchronous clear; head is read combinationally.
module mips_issue_ctrl_fifo
  import mips_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_data_i,
  input  logic               pop_i,
  input  logic               clear_i,
  output logic [INSTR_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [FCNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= PTR_W'(wr_q + PTR_W'(1));
      if (pop_i)  rd_q <= PTR_W'(rd_q + PTR_W'(1));
      if (push_i && !pop_i)      cnt_q <= FCNT_W'(cnt_q + FCNT_W'(1));
      else if (pop_i && !push_i) cnt_q <= FCNT_W'(cnt_q - FCNT_W'(1));
    end
  end

  // storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == FCNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mips_issue_ctrl.sv
// Issue controller: buffers fetched words, inserts load-use bubbles and flushes on taken branches.
module mips_issue_ctrl
  import mips_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_issue_ctrl_if.slave   bus
);
  localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  logic [ST_W-1:0]    state_q, state_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               lw_flag_q, lw_flag_d;
  logic [REG_W-1:0]   lw_rt_q, lw_rt_d;
  logic [CNT_W-1:0]   bub_q, bub_d;
  logic [CNT_W-1:0]   flu_q, flu_d;

  logic [INSTR_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty;
  logic               push, pop, clear;
  logic               hazard;
  instr_t             head;

  assign bus.in_ready = !fifo_full && (state_q != ST_FLUSH) && !bus.br_taken;
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = instr_t'(fifo_head);

  // load-use: previous issue was an LW writing a register the head reads
  assign hazard = lw_flag_q && (lw_rt_q != '0) &&
                  ((head.rs == lw_rt_q) || (reads_rt(head.op) && (head.rt == lw_rt_q)));

  mips_issue_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (bus.in_instr),
    .pop_i       (pop),
    .clear_i     (clear),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      lw_flag_q <= 1'b0;
      lw_rt_q   <= '0;
      bub_q     <= '0;
      flu_q     <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      lw_flag_q <= lw_flag_d;
      lw_rt_q   <= lw_rt_d;
      bub_q     <= bub_d;
      flu_q     <= flu_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    lw_flag_d = lw_flag_q;
    lw_rt_d   = lw_rt_q;
    bub_d     = bub_q;
    flu_d     = flu_q;
    pop       = 1'b0;
    clear     = 1'b0;

    if (bus.br_taken) begin
      clear     = 1'b1;
      lw_flag_d = 1'b0;
      instr_d   = NOP_WORD;
      valid_d   = 1'b0;
      flu_d     = (&flu_q) ? flu_q : CNT_W'(flu_q + CNT_W'(1));
      fcnt_d    = FC_W'(FLUSH_CYC - 1);
      state_d   = ST_FLUSH;
    end else if (!bus.hold) begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (fifo_empty) begin
            instr_d   = NOP_WORD;
            valid_d   = 1'b0;
            lw_flag_d = 1'b0;
            state_d   = ST_RUN;
          end else if (hazard && (state_q == ST_RUN)) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            bub_d   = (&bub_q) ? bub_q : CNT_W'(bub_q + CNT_W'(1));
            state_d = ST_STALL;
          end else begin
            // the bubble (if any) is spent; issue head and track it as last op
            pop       = 1'b1;
            instr_d   = INSTR_W'(head);
            valid_d   = 1'b1;
            lw_flag_d = (head.op == OP_LW);
            lw_rt_d   = head.rt;
            state_d   = ST_RUN;
          end
        end
        ST_FLUSH: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (fcnt_q == '0) state_d = ST_RUN;
          else              fcnt_d  = FC_W'(fcnt_q - FC_W'(1));
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign bus.issue_instr = instr_q;
  assign bus.issue_valid = valid_q;
  assign bus.bubble_cnt  = bub_q;
  assign bus.flush_cnt   = flu_q;

endmodule

// File: tb/tb_mips_issue_ctrl.sv
// Bench for mips_issue_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_mips_issue_ctrl;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int          MAXC      = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  mips_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_issue_ctrl #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queue of buffered words plus a few plain counters
  logic [31:0] m_q[$];
  logic [31:0] m_instr;
  logic        m_valid;
  int          m_bub, m_flu, m_flush_left, m_last_rt;
  bit          m_stalled;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_instr = 32'h0; m_valid = 1'b0;
    m_bub = 0; m_flu = 0; m_flush_left = 0; m_last_rt = -1; m_stalled = 0;
  endfunction

  function automatic bit m_ready(input bit br);
    return (m_q.size() < DEPTH) && (m_flush_left == 0) && !br;
  endfunction

  function automatic bit m_hazard(input logic [31:0] w);
    int op, rs, rt;
    bit uses_rt;
    op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
    uses_rt = (op == 0) || (op == 'h2B) || (op == 'h04);
    return (m_last_rt > 0) && ((rs == m_last_rt) || (uses_rt && rt == m_last_rt));
  endfunction

  function automatic void m_issue_head();
    logic [31:0] w;
    w = m_q.pop_front();
    m_instr = w; m_valid = 1'b1;
    m_last_rt = (w[31:26] == 6'b100011) ? int'(w[20:16]) : -1;
  endfunction

  function automatic void m_nop();
    m_instr = 32'h0; m_valid = 1'b0;
  endfunction

  function automatic void model_step(input bit v, input logic [31:0] w, input bit hold, input bit br);
    bit push;
    push = v && m_ready(br);
    if (br) begin
      m_q.delete();
      m_last_rt = -1; m_stalled = 0;
      m_nop();
      if (m_flu < MAXC) m_flu++;
      m_flush_left = FLUSH_CYC;
    end else if (!hold) begin
      if (m_flush_left > 0) begin
        m_nop(); m_flush_left--;
      end else if (m_stalled) begin
        m_issue_head(); m_stalled = 0;
      end else if (m_q.size() == 0) begin
        m_nop(); m_last_rt = -1;
      end else if (m_hazard(m_q[0])) begin
        m_nop(); m_stalled = 1;
        if (m_bub < MAXC) m_bub++;
      end else begin
        m_issue_head();
      end
    end
    if (push) m_q.push_back(w);
  endfunction

  task automatic cycle(input bit v, input logic [31:0] w, input bit hold, input bit br);
    @(negedge clk);
    bus.in_valid = v; bus.in_instr = w; bus.hold = hold; bus.br_taken = br;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready(br)));
    @(posedge clk);
    model_step(v, w, hold, br);
    #1;
    chk("issue_instr", bus.issue_instr, m_instr);
    chk("issue_valid", 32'(bus.issue_valid), 32'(m_valid));
    chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_bub));
    chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flu));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] op;
    logic [4:0] rs, rt;
    case ($urandom_range(0, 4))
      0: op = 6'b000000;
      1: op = 6'b100011;
      2: op = 6'b101011;
      3: op = 6'b000100;
      default: op = 6'b001000;
    endcase
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    return {op, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.hold = 1'b0; bus.br_taken = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.issue_valid), 32'h0);
    chk("rst_instr", bus.issue_instr, 32'h0);

    // async reset with three words queued and a live instruction on the output
    cycle(1'b1, 32'h00E91020, 1'b0, 1'b0);
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0);
    cycle(1'b1, 32'h22222222, 1'b1, 1'b0);
    cycle(1'b1, 32'h33333333, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(bus.issue_valid), 32'h1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.hold = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.issue_valid), 32'h0);
    chk("arst_instr", bus.issue_instr, 32'h0);
    chk("arst_ready", 32'(bus.in_ready), 32'h1);
    chk("arst_bub", 32'(bus.bubble_cnt), 32'h0);
    chk("arst_flu", 32'(bus.flush_cnt), 32'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // back-to-back independent words
    cycle(1'b1, 32'h00E91020, 1'b0, 1'b0);
    cycle(1'b1, 32'h8CE50006, 1'b0, 1'b0);
    chk("t2_add", bus.issue_instr, 32'h00E91020);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t2_lw", bus.issue_instr, 32'h8CE50006);
    chk("t2_bub", 32'(bus.bubble_cnt), 32'h0);
    idle(2);

    // load-use: LW R5 then SW reading R5 -> one bubble
    cycle(1'b1, 32'h8CE50006, 1'b0, 1'b0);
    cycle(1'b1, 32'hACA20004, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_bubble_v", 32'(bus.issue_valid), 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_sw", bus.issue_instr, 32'hACA20004);
    chk("t3_bub", 32'(bus.bubble_cnt), 32'h1);
    idle(2);
    cycle(1'b1, 32'h8CE50006, 1'b0, 1'b0);
    cycle(1'b1, 32'h00E91020, 1'b0, 1'b0);
    idle(2);
    chk("t3_nobub", 32'(bus.bubble_cnt), 32'h1);

    // taken branch flushes queued wrong-path words
    cycle(1'b1, 32'h104A1822, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA0003, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t4_flu", 32'(bus.flush_cnt), 32'h1);
    cycle(1'b1, 32'hBBBB0000, 1'b0, 1'b0);
    chk("t4_flush_ready", 32'(bus.in_ready), 32'h0);
    cycle(1'b1, 32'hBBBB0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h01234567, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_next", bus.issue_instr, 32'h01234567);

    // hold while filling: fifth push refused, output frozen
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hC0DE0000 + 32'(i), 1'b1, 1'b0);
    chk("t5_full_ready", 32'(bus.in_ready), 32'h0);
    chk("t5_frozen", bus.issue_instr, 32'h01234567);
    idle(6);

    // saturate the bubble counter
    for (int i = 0; i < MAXC + 4; i++) begin
      cycle(1'b1, 32'h8C010000, 1'b0, 1'b0);
      cycle(1'b1, 32'hAC200000, 1'b0, 1'b0);
      idle(3);
    end
    chk("t6_sat", 32'(bus.bubble_cnt), 32'(MAXC));

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 4) < 3, rnd_instr(), $urandom_range(0, 4) == 0,
            $urandom_range(0, 24) == 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
